ram_1wrs_arbiter: RTL
=====================

// Module: ram_1wrs_arbiter
// PURPOSE
//  Round-robin arbiter sharing one single-port RAM (1 read/write port, byte mask) between two requesters, A and B.
//  Each requester has a valid/ready command channel and a read-response channel with no backpressure.
//  RAM-side command outputs are registered. The block sits between two client engines and a Ram_1wrs instance.
// PARAMETERS
//  WORD_COUNT   128                  RAM depth in words
//  WORD_WIDTH   64                   data width in bits; must be a multiple of 8
//  ADDR_WIDTH   $clog2(WORD_COUNT)   address width
//  MASK_WIDTH   WORD_WIDTH/8         byte-enable width
//  RD_LATENCY   1                    RAM read latency, ram_en to valid ram_rdData; legal values 1 or 2
// PORTS
//  clk          in   1           single clock; all logic is rising-edge
//  reset        in   1           synchronous, active-high
//  a_cmd_valid  in   1           requester A command present
//  a_cmd_ready  out  1           A command accepted this cycle
//  a_cmd_write  in   1           1 = write, 0 = read
//  a_cmd_addr   in   ADDR_WIDTH  word address
//  a_cmd_mask   in   MASK_WIDTH  byte enables; writes only
//  a_cmd_data   in   WORD_WIDTH  write data
//  a_rsp_valid  out  1           A read data valid; one-cycle pulse
//  a_rsp_data   out  WORD_WIDTH  A read data
//  b_cmd_*/b_rsp_*               identical to the A ports, for requester B
//  ram_en       out  1           RAM enable
//  ram_wr       out  1           RAM write strobe
//  ram_addr     out  ADDR_WIDTH  RAM address
//  ram_mask     out  MASK_WIDTH  RAM byte mask
//  ram_wrData   out  WORD_WIDTH  RAM write data
//  ram_rdData   in   WORD_WIDTH  RAM read data
// BEHAVIOUR
//  Reset
//   - ram_en, ram_wr, a/b_rsp_valid = 0; ram_addr/mask/wrData = 0.
//   - Priority pointer = A. All in-flight read tags cleared.
//  Arbitration (combinational, same cycle)
//   - One grant per cycle; no idle cycle between grants.
//   - Only one requester valid: it is granted.
//   - Both valid: the requester named by the pointer is granted.
//   - x_cmd_ready = grant to x. Ready is never asserted without valid.
//   - Pointer update on any grant: pointer <= the non-granted requester.
//     Result: strict alternation under contention; a requester waits at most 1 cycle.
//   - No grant: pointer holds.
//  Command issue
//   - Accept at cycle N -> at N+1: ram_en = 1, ram_wr = cmd_write, ram_addr/mask/wrData = cmd fields.
//   - No accept at N -> ram_en = 0 and ram_wr = 0 at N+1; other RAM outputs hold.
//   - Reads drive ram_mask = all ones.
//  Read response
//   - Tag pipeline (valid + owner), depth 1+RD_LATENCY.
//   - Owner's x_rsp_valid = 1 at cycle N+1+RD_LATENCY; x_rsp_data = ram_rdData.
//   - Non-owner rsp_valid = 0; its rsp_data is don't-care but holds the last value.
//   - Writes produce no response.
//   - Responses return in issue order. Up to 1+RD_LATENCY reads in flight.
//  Boundaries
//   - Same-address write then read, back-to-back: the read returns the new data (RAM ordering; writes are not bypassed).
//   - Reset mid-operation: every tag is dropped; no rsp_valid is raised from the cycle after reset asserts.
//   - Commands presented while reset = 1 are not accepted.
//   - Address is not range-checked; addr >= WORD_COUNT is passed through unchanged.
//   - Throughput: 1 command per cycle in aggregate; 100% to a single active requester.
// TESTING
//  1. A write addr 5, data 0x1122334455667788, mask 0xFF; then A read 5 -> at accept+2, a_rsp_valid = 1 with that data; b_rsp_valid stays 0.
//  2. A and B both valid for 6 cycles after reset -> grants A,B,A,B,A,B; each ready is high every other cycle.
//  3. Only B valid for 4 cycles -> b_cmd_ready high all 4 cycles; ram_en high at cycles 2-5.
//  4. Masked write mask 0x0F, data all ones, over 0 -> read returns 0x00000000FFFFFFFF.
//  5. RD_LATENCY=2, alternating A/B reads -> each rsp at accept+3, tagged to the correct owner, in order.
//  6. Reset asserted 1 cycle after a read is accepted -> no rsp_valid occurs; pointer = A after release.

Source files
------------

// File: rtl/ram_1wrs_arbiter.sv
// Round-robin arbiter that lets two requesters share one single-port, byte-masked RAM.
// RAM commands are registered, and read responses are routed back using an owner tag pipeline.
module ram_1wrs_arbiter #(
   parameter int WORD_COUNT = 128,
   parameter int WORD_WIDTH = 64,
   parameter int ADDR_WIDTH = $clog2(WORD_COUNT),
   parameter int MASK_WIDTH = WORD_WIDTH / 8,
   parameter int RD_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  a_cmd_valid,
   output logic                  a_cmd_ready,
   input  logic                  a_cmd_write,
   input  logic [ADDR_WIDTH-1:0] a_cmd_addr,
   input  logic [MASK_WIDTH-1:0] a_cmd_mask,
   input  logic [WORD_WIDTH-1:0] a_cmd_data,
   output logic                  a_rsp_valid,
   output logic [WORD_WIDTH-1:0] a_rsp_data,
   input  logic                  b_cmd_valid,
   output logic                  b_cmd_ready,
   input  logic                  b_cmd_write,
   input  logic [ADDR_WIDTH-1:0] b_cmd_addr,
   input  logic [MASK_WIDTH-1:0] b_cmd_mask,
   input  logic [WORD_WIDTH-1:0] b_cmd_data,
   output logic                  b_rsp_valid,
   output logic [WORD_WIDTH-1:0] b_rsp_data,
   output logic                  ram_en,
   output logic                  ram_wr,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [MASK_WIDTH-1:0] ram_mask,
   output logic [WORD_WIDTH-1:0] ram_wrData,
   input  logic [WORD_WIDTH-1:0] ram_rdData
);

   localparam int DEPTH = 1 + RD_LATENCY;

   typedef enum logic {OWNER_A = 1'b0, OWNER_B = 1'b1} owner_t;

   owner_t                  pointer;
   logic                    grant_a;
   logic                    grant_b;
   logic                    grant_any;
   logic                    sel_write;
   logic [ADDR_WIDTH-1:0]   sel_addr;
   logic [MASK_WIDTH-1:0]   sel_mask;
   logic [WORD_WIDTH-1:0]   sel_data;
   logic [DEPTH-1:0]        tag_valid;
   logic [DEPTH-1:0]        tag_owner;
   logic                    a_fire;
   logic                    b_fire;
   logic [WORD_WIDTH-1:0]   a_hold;
   logic [WORD_WIDTH-1:0]   b_hold;

   // Grants are gated by reset so that nothing is accepted while reset is held.
   always_comb begin
      grant_a   = !reset && a_cmd_valid && (!b_cmd_valid || pointer == OWNER_A);
      grant_b   = !reset && b_cmd_valid && (!a_cmd_valid || pointer == OWNER_B);
      grant_any = grant_a || grant_b;
      sel_write = grant_b ? b_cmd_write : a_cmd_write;
      sel_addr  = grant_b ? b_cmd_addr  : a_cmd_addr;
      sel_mask  = grant_b ? b_cmd_mask  : a_cmd_mask;
      sel_data  = grant_b ? b_cmd_data  : a_cmd_data;
   end

   assign a_cmd_ready = grant_a;
   assign b_cmd_ready = grant_b;

   always_ff @(posedge clk) begin
      if (reset) begin
         pointer    <= OWNER_A;
         ram_en     <= 1'b0;
         ram_wr     <= 1'b0;
         ram_addr   <= '0;
         ram_mask   <= '0;
         ram_wrData <= '0;
         tag_valid  <= '0;
         tag_owner  <= '0;
      end else begin
         if (grant_a) begin
            pointer <= OWNER_B;
         end else if (grant_b) begin
            pointer <= OWNER_A;
         end
         ram_en <= grant_any;
         ram_wr <= grant_any && sel_write;
         if (grant_any) begin
            ram_addr   <= sel_addr;
            ram_mask   <= sel_write ? sel_mask : '1;
            ram_wrData <= sel_data;
         end
         // Stage k holds the read issued to the RAM k cycles ago; the last stage lines up with ram_rdData.
         tag_valid <= {tag_valid[DEPTH-2:0], grant_any && !sel_write};
         tag_owner <= {tag_owner[DEPTH-2:0], grant_b};
      end
   end

   assign a_fire = !reset && tag_valid[RD_LATENCY] && !tag_owner[RD_LATENCY];
   assign b_fire = !reset && tag_valid[RD_LATENCY] &&  tag_owner[RD_LATENCY];

   // The live RAM data is forwarded on the response cycle, and a copy is kept so each port holds its last value.
   always_ff @(posedge clk) begin
      if (reset) begin
         a_hold <= '0;
         b_hold <= '0;
      end else begin
         if (a_fire) begin
            a_hold <= ram_rdData;
         end
         if (b_fire) begin
            b_hold <= ram_rdData;
         end
      end
   end

   assign a_rsp_valid = a_fire;
   assign b_rsp_valid = b_fire;
   assign a_rsp_data  = a_fire ? ram_rdData : a_hold;
   assign b_rsp_data  = b_fire ? ram_rdData : b_hold;

endmodule
